inert_seq: RTL and testbench

Sequencer that owns the `SPI_mnrch` monarch and the iNEMO inertial sensor behind it. After reset it waits for the sensor to settle, then writes a fixed configuration list. It then services the sensor's data-ready `INT` by reading yaw-rate and X-acceleration register pairs. It assembles the 16-bit results and presents them with a one-cycle valid strobe to the integrator downstream.

---
 rtl/inert_seq_if.sv | 11 +
 rtl/inert_seq.sv | 151 +++++++++++++++
 tb/tb_inert_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inert_seq_if.sv
// Command/response bundle between the inertial sequencer and the SPI monarch.
// The sequencer is the master: it issues wrt/cmd and receives done/rd_data.
interface inert_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, cmd, input done, rd_data);
  modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/inert_seq.sv
// Sequencer for the iNEMO inertial sensor: settle, write the configuration list,
// then on each data-ready interrupt read yaw-rate and X-accel and publish them.
module inert_seq #(
  parameter int SETTLE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  inert_seq_if.master spi,
  output logic        cfg_done,
  output logic [15:0] yaw_rt,
  output logic [15:0] ax,
  output logic        vld
);

  typedef enum logic [2:0] {SETTLE, CFG, CFG_W, IDLE, RD, RD_W} state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          sync_q, sync_d;
  logic                wrt_q, wrt_d;
  logic [15:0]         cmd_q, cmd_d;
  logic                cfg_done_q, cfg_done_d;
  logic [15:0]         yaw_q, yaw_d;
  logic [15:0]         ax_q, ax_d;
  logic                vld_q, vld_d;
  logic [7:0]          hold_q [4];
  logic [7:0]          hold_d [4];
  logic                int_s;
  logic                unused_rd_hi;

  assign int_s        = sync_q[1];
  assign unused_rd_hi = ^spi.rd_data[15:8];

  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1053;
      2'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  // Read commands walk 0xA6..0xA9; low byte is a don't-care dummy.
  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    return {8'hA6 + {6'd0, i}, 8'h00};
  endfunction

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    sync_d     = {sync_q[0], INT};
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    cfg_done_d = cfg_done_q;
    yaw_d      = yaw_q;
    ax_d       = ax_q;
    vld_d      = 1'b0;
    hold_d     = hold_q;
    case (state_q)
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == '1) begin
          state_d = CFG;
          idx_d   = 2'd0;
          cmd_d   = cfg_cmd(2'd0);
          wrt_d   = 1'b1;
        end
      end
      CFG: state_d = CFG_W;
      CFG_W: begin
        if (spi.done) begin
          if (idx_q == 2'd3) begin
            cfg_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            cmd_d   = cfg_cmd(idx_q + 2'd1);
            wrt_d   = 1'b1;
            state_d = CFG;
          end
        end
      end
      IDLE: begin
        if (int_s) begin
          state_d = RD;
          idx_d   = 2'd0;
          cmd_d   = rd_cmd(2'd0);
          wrt_d   = 1'b1;
        end
      end
      RD: state_d = RD_W;
      RD_W: begin
        if (spi.done) begin
          hold_d[idx_q] = spi.rd_data[7:0];
          // Outputs only move once all four bytes of a set are in hand.
          if (idx_q == 2'd3) begin
            yaw_d   = {hold_d[1], hold_d[0]};
            ax_d    = {hold_d[3], hold_d[2]};
            vld_d   = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            cmd_d   = rd_cmd(idx_q + 2'd1);
            wrt_d   = 1'b1;
            state_d = RD;
          end
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SETTLE;
      settle_q   <= '0;
      idx_q      <= 2'd0;
      sync_q     <= 2'b00;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      cfg_done_q <= 1'b0;
      yaw_q      <= 16'h0000;
      ax_q       <= 16'h0000;
      vld_q      <= 1'b0;
      for (int i = 0; i < 4; i++) hold_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      sync_q     <= sync_d;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      cfg_done_q <= cfg_done_d;
      yaw_q      <= yaw_d;
      ax_q       <= ax_d;
      vld_q      <= vld_d;
      hold_q     <= hold_d;
    end
  end

  assign spi.wrt  = wrt_q;
  assign spi.cmd  = cmd_q;
  assign cfg_done = cfg_done_q;
  assign yaw_rt   = yaw_q;
  assign ax       = ax_q;
  assign vld      = vld_q;

endmodule

// File: tb/tb_inert_seq.sv
// Bench for inert_seq: mock SPI monarch plus iNEMO register model on the negedge,
// table-driven and random read sets, and hand-written corner-case sequences.
module tb_inert_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_line;
  logic        cfg_done;
  logic        vld;
  logic [15:0] yaw_rt;
  logic [15:0] ax;

  inert_seq_if spi ();

  inert_seq #(.SETTLE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .INT      (int_line),
    .spi      (spi),
    .cfg_done (cfg_done),
    .yaw_rt   (yaw_rt),
    .ax       (ax),
    .vld      (vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a6, a7, a8, a9;
    logic [15:0] exp_yaw, exp_ax;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] cfg_list [4];
  logic [7:0]  sreg [4];
  logic [15:0] wlog [$];
  int          vld_cycs [$];

  int vec_cnt = 0, miscompare_cnt = 0;
  int cyc = 0, vld_cnt = 0, done_cyc = -100, cfg_cyc = 0, rd_start_cyc = 0, int_cyc = 0;
  int proto_err = 0, gap_err = 0, hold_err = 0, cfg_seen = 0, lat = 0;
  bit busy = 0, stray_req = 0, prev_cfg_done = 0;
  logic        int_at_a7 = 1'b1;
  logic [15:0] cur_cmd = 16'h0000, last_done_cmd = 16'h0000;
  logic [15:0] model_yaw, model_ax;

  function automatic bit isRead(input logic [15:0] c);
    return (c[15:8] >= 8'hA6) && (c[15:8] <= 8'hA9);
  endfunction

  function automatic logic [7:0] sensorRead(input logic [15:0] c);
    logic [7:0] off;
    off = c[15:8] - 8'hA6;
    return sreg[off[1:0]];
  endfunction

  // Mock monarch + sensor: accepts a wrt, answers done after a random latency.
  initial begin
    spi.done    = 1'b0;
    spi.rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      spi.done    = 1'b0;
      spi.rd_data = 16'($urandom);
      if (rst) begin
        if (spi.wrt) proto_err++;
        busy          = 0;
        prev_cfg_done = 0;
      end else begin
        if (vld) begin
          vld_cnt++;
          vld_cycs.push_back(cyc);
          if (cyc - done_cyc != 1 || last_done_cmd != 16'hA900) gap_err++;
        end
        if (cfg_done && !prev_cfg_done) begin
          cfg_cyc = cyc;
          if (cyc - done_cyc != 1 || last_done_cmd != 16'h1460) gap_err++;
        end
        prev_cfg_done = cfg_done;
        if (busy) begin
          if (spi.wrt) proto_err++;
          if (spi.cmd != cur_cmd) hold_err++;
          if (lat == 0) begin
            spi.done = 1'b1;
            if (isRead(cur_cmd)) spi.rd_data = {8'($urandom), sensorRead(cur_cmd)};
            if (cur_cmd == 16'hA600) int_line = 1'b0;
            busy          = 0;
            done_cyc      = cyc;
            last_done_cmd = cur_cmd;
          end else begin
            lat--;
          end
        end else if (spi.wrt) begin
          if (spi.cmd != 16'h0D02 && spi.cmd != 16'hA600 && cyc - done_cyc != 1) gap_err++;
          if (isRead(spi.cmd) && !cfg_done) proto_err++;
          if (spi.cmd == 16'hA600) rd_start_cyc = cyc;
          if (spi.cmd == 16'hA700) int_at_a7 = int_line;
          if (cfg_seen < 4 && spi.cmd == cfg_list[cfg_seen[1:0]]) cfg_seen++;
          wlog.push_back(spi.cmd);
          cur_cmd = spi.cmd;
          busy    = 1;
          lat     = int'($urandom_range(0, 3));
        end else if (stray_req) begin
          spi.done  = 1'b1;
          stray_req = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompare_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] a6, a7, a8, a9);
    tick(1);
    sreg[0]   = a6; sreg[1] = a7; sreg[2] = a8; sreg[3] = a9;
    model_yaw = {a7, a6};
    model_ax  = {a9, a8};
    wlog.delete();
    int_cyc   = cyc;
    int_line  = 1'b1;
  endtask

  task automatic waitVld(input int target, input string name);
    int n = 0;
    while (vld_cnt < target && n < 300) begin tick(1); n++; end
    checkOutput(name, 32'(vld_cnt >= target), 1);
  endtask

  task automatic waitCfg(input string name);
    int n = 0;
    while (!cfg_done && n < 300) begin tick(1); n++; end
    checkOutput(name, 32'(cfg_done), 1);
  endtask

  task automatic waitLog(input int target, input string name);
    int n = 0;
    while (wlog.size() < target && n < 300) begin tick(1); n++; end
    checkOutput(name, 32'(wlog.size() >= target), 1);
  endtask

  task automatic checkReads(input int base, input string name);
    logic [15:0] got;
    for (int i = 0; i < 4; i++) begin
      got = (base + i < wlog.size()) ? wlog[base + i] : 16'hDEAD;
      checkOutput(name, got, {8'hA6 + 8'(i), 8'h00});
    end
  endtask

  task automatic checkCfgList(input string name);
    logic [15:0] got;
    for (int i = 0; i < 4; i++) begin
      got = (i < wlog.size()) ? wlog[i] : 16'hDEAD;
      checkOutput(name, got, cfg_list[i]);
    end
    checkOutput({name, "_nemo_setup"}, 32'(cfg_seen == 4), 1);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_wrt"},      32'(spi.wrt),  0);
    checkOutput({name, "_cmd"},      32'(spi.cmd),  0);
    checkOutput({name, "_cfg_done"}, 32'(cfg_done), 0);
    checkOutput({name, "_yaw"},      32'(yaw_rt),   0);
    checkOutput({name, "_ax"},       32'(ax),       0);
    checkOutput({name, "_vld"},      32'(vld),      0);
  endtask

  initial begin
    int base, n_cfg, gap;
    logic [7:0] r6, r7, r8, r9;

    cfg_list = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    vecs[0] = '{8'hA6, 8'h12, 8'h34, 8'h56, 16'h12A6, 16'h5634};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 16'h8001, 16'hFE7F};
    vecs[4] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 16'hC35A, 16'hF00F};

    // Early INT: line held high from time zero through settle and config.
    rst = 1'b1;
    int_line = 1'b1;
    sreg = '{8'hA6, 8'h12, 8'h34, 8'h56};
    model_yaw = 16'h12A6;
    model_ax  = 16'h5634;
    tick(3);
    checkReset("reset");
    rst = 1'b0;

    waitCfg("cfg_done_timeout");
    checkCfgList("cfg_cmd");
    waitVld(1, "early_int_vld_timeout");
    tick(3);
    gap = rd_start_cyc - cfg_cyc;
    checkOutput("early_int_first_read_gap", 32'(gap >= 1 && gap <= 2), 1);
    n_cfg = 0;
    foreach (wlog[i]) if (!isRead(wlog[i])) n_cfg++;
    checkOutput("cfg_wrt_count", 32'(n_cfg), 4);
    checkReads(4, "early_int_read_cmd");
    checkOutput("int_low_by_a7", 32'(int_at_a7), 0);
    checkOutput("early_yaw", 32'(yaw_rt), 32'(model_yaw));
    checkOutput("early_ax",  32'(ax),     32'(model_ax));
    checkOutput("early_vld_count", 32'(vld_cnt), 1);

    // Table-driven read sets.
    for (int i = 0; i < 5; i++) begin
      base = vld_cnt;
      applyStimulus(vecs[i].a6, vecs[i].a7, vecs[i].a8, vecs[i].a9);
      waitVld(base + 1, "tbl_vld_timeout");
      checkOutput("tbl_yaw", 32'(yaw_rt), 32'(vecs[i].exp_yaw));
      checkOutput("tbl_ax",  32'(ax),     32'(vecs[i].exp_ax));
      tick(4);
      checkOutput("tbl_int_latency", 32'(rd_start_cyc - int_cyc), 4);
      checkOutput("tbl_read_count", 32'(wlog.size()), 4);
      checkOutput("tbl_vld_once", 32'(vld_cnt), 32'(base + 1));
      checkReads(0, "tbl_read_cmd");
    end

    // Randomized read sets against the register model.
    for (int i = 0; i < 8; i++) begin
      r6 = 8'($urandom); r7 = 8'($urandom); r8 = 8'($urandom); r9 = 8'($urandom);
      base = vld_cnt;
      applyStimulus(r6, r7, r8, r9);
      waitVld(base + 1, "rnd_vld_timeout");
      checkOutput("rnd_yaw", 32'(yaw_rt), 32'(model_yaw));
      checkOutput("rnd_ax",  32'(ax),     32'(model_ax));
      tick(int'($urandom_range(3, 6)));
      checkOutput("rnd_read_count", 32'(wlog.size()), 4);
    end

    // Stray done in IDLE must be ignored entirely.
    base = vld_cnt;
    wlog.delete();
    stray_req = 1;
    tick(6);
    checkOutput("stray_no_wrt", 32'(wlog.size()), 0);
    checkOutput("stray_no_vld", 32'(vld_cnt), 32'(base));
    checkOutput("stray_yaw", 32'(yaw_rt), 32'(model_yaw));
    checkOutput("stray_ax",  32'(ax),     32'(model_ax));
    checkOutput("stray_cfg_done", 32'(cfg_done), 1);
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    waitVld(base + 1, "stray_vld_timeout");
    tick(3);
    checkReads(0, "stray_read_cmd");
    checkOutput("stray_yaw_after", 32'(yaw_rt), 32'h2211);
    checkOutput("stray_ax_after",  32'(ax),     32'h4433);

    // INT re-raised during the 0xA9 transaction is serviced once more.
    base = vld_cnt;
    applyStimulus(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    waitLog(4, "reint_a9_timeout");
    int_line = 1'b1;
    waitVld(base + 2, "reint_vld_timeout");
    tick(6);
    checkOutput("reint_vld_count", 32'(vld_cnt), 32'(base + 2));
    checkOutput("reint_read_count", 32'(wlog.size()), 8);
    checkReads(0, "reint_read_cmd_1");
    checkReads(4, "reint_read_cmd_2");
    gap = (vld_cycs.size() > base) ? rd_start_cyc - vld_cycs[base] : -1;
    checkOutput("reint_gap", 32'(gap >= 1 && gap <= 2), 1);
    checkOutput("reint_yaw", 32'(yaw_rt), 32'hBC9A);
    checkOutput("reint_ax",  32'(ax),     32'hF0DE);

    // Reset one cycle after the 0xA8 wrt, then full replay.
    applyStimulus(8'h01, 8'h02, 8'h03, 8'h04);
    waitLog(3, "midrd_a8_timeout");
    rst = 1'b1;
    tick(1);
    checkReset("midrd_reset");
    tick(1);
    wlog.delete();
    cfg_seen = 0;
    rst = 1'b0;
    waitCfg("replay_cfg_timeout");
    checkCfgList("replay_cfg_cmd");
    checkOutput("replay_yaw_zero", 32'(yaw_rt), 0);
    checkOutput("replay_ax_zero",  32'(ax),     0);
    base = vld_cnt;
    applyStimulus(8'h77, 8'h66, 8'h55, 8'h44);
    waitVld(base + 1, "replay_vld_timeout");
    checkOutput("replay_yaw", 32'(yaw_rt), 32'h6677);
    checkOutput("replay_ax",  32'(ax),     32'h4455);
    tick(3);

    checkOutput("protocol_errors", 32'(proto_err), 0);
    checkOutput("timing_errors",   32'(gap_err),   0);
    checkOutput("cmd_hold_errors", 32'(hold_err),  0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
